mul_sequencer: RTL and testbench
================================

# mul_sequencer

Bus-master sequencer that shares the memory-mapped Multiplier slave between two client requesters. For each granted request it writes the 64-bit operands, issues the opcode and start pulse, waits for `m_interrupt`, reads back the 128-bit product, clears the interrupt and returns the result to the client. It sits between the client logic and the Multiplier's `S_*` slave port and is the slave's only bus master.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before the request aborts with an error.
- `clk`  in  1  system clock; all flops rise-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  client request; each is held high until the matching `done` pulse.
- `a0`, `b0`, `a1`, `b1`  in  64 each  operands per client; held stable while the matching `req` is high.
- `done0`, `done1`  out  1  one-cycle completion pulse to the client.
- `result`  out  128  product of the last completed request; valid when a `done` pulse is high and held until the next capture.
- `err`  out  1  high together with `done` when the request timed out.
- `busy`  out  1  high in every state except IDLE.
- `M_sel`, `M_wr`  out  1  bus select and write strobe to the slave.
- `M_address`  out  8  slave register address.
- `M_din`  out  32  write data.
- `M_dout`  in  32  read data from the slave; registered, valid one cycle after the address is presented.
- `m_interrupt`  in  1  slave completion flag; level, stays high until cleared.

## Operation
- Slave register map:
  - 0x0 / 0x1: A low / high word.
  - 0x2 / 0x3: B low / high word.
  - 0x4–0x7: product words, low to high.
  - 0x8: opcode (1 = multiply).
  - 0xA: start.
  - 0xB: interrupt clear (write 1).
- States: IDLE → WRITE → WAIT → READ → CLEAR → DONE → IDLE.
- **IDLE:**
  - One request pending: grant it.
  - Both pending: grant the requester not served last. `last_grant` resets to 1, so `req0` wins the first tie.
  - On grant: latch the operands into internal registers, record the grant, go to WRITE.
- **WRITE:** 7 cycles, step counter 0..6, `M_sel`=1 and `M_wr`=1 each cycle. (address, data) per step: (0x0, A[31:0]), (0x1, A[63:32]), (0x2, B[31:0]), (0x3, B[63:32]), (0x8, 1), (0xA, 1), (0xA, 0).
- **WAIT:**
  - `M_sel`=0, wait counter increments each cycle.
  - `m_interrupt`=1 → READ.
  - Counter reaches `TIMEOUT` → set the error flag, go to CLEAR, skip READ. `result` keeps its previous value.
- **READ:** 5 cycles, counter 0..4, `M_sel`=1, `M_wr`=0.
  - Counter 0..3: `M_address` = 0x4 + counter.
  - Counter 1..4: capture `M_dout` into `result` word (counter−1).
- **CLEAR:** 1 cycle, write 0xB = 1.
- **DONE:** 1 cycle.
  - Pulse the `done` of the granted requester; `err` = error flag.
  - Update `last_grant`, clear the error flag, go to IDLE.
- Bus outputs are registered. Outside WRITE, READ and CLEAR: `M_sel`=0, `M_wr`=0, `M_address`=0, `M_din`=0.
- `req` deasserted mid-operation is ignored; the sequence always runs to DONE.
- `m_interrupt` already high on entry to WAIT is accepted immediately (1 WAIT cycle).

## Timing
- Reset: state IDLE; all outputs 0 (`result`=0, `done0`/`done1`/`err`/`busy`=0, bus outputs 0); counters 0; `last_grant`=1.
- Reset asserted mid-operation aborts immediately. No `done` is issued and the slave is not cleared; recovery is the system reset of the slave.
- Grant: the first cycle with `req` high in IDLE. The first WRITE cycle follows on the next edge.
- Total latency from the grant edge to the `done` pulse = 1 + 7 + W + 5 + 1 + 1 cycles, where W = WAIT cycles (≥1).
- Back-to-back: a new grant is possible in the cycle after DONE. Minimum gap between operations is one IDLE cycle.
- Timeout path latency: 1 + 7 + `TIMEOUT` + 1 + 1 cycles.

## Test plan
- **Single request:** `req0` with A=0x20, B=0x19; model slave raises `m_interrupt` 36 cycles after start.
  - Bus trace matches the 7-write sequence, 4 reads at 0x4–0x7, then write 0xB=1.
  - `result`=0x320, `done0` pulses once, `err`=0.
- **Tie arbitration:** `req0` and `req1` raised in the same cycle and kept high with new operands after each done.
  - Service order 0, 1, 0, 1.
  - Each `result` is correct for its own requester's operands.
- **Full-width operands:** A = B = 0xFFFF_FFFF_FFFF_FFFF.
  - `result` = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, with words captured in the correct order.
- **Timeout:** `TIMEOUT`=16, `m_interrupt` never asserted.
  - `done0` with `err`=1 exactly 26 cycles after the grant edge.
  - `result` unchanged, clear write still issued.
- **Reset mid-WAIT:** assert `reset` during WAIT.
  - All outputs 0 asynchronously, `busy`=0, no `done` pulse.
  - After release, a new request completes normally.
- **Early interrupt:** `m_interrupt` stuck high on entry to WAIT.
  - W=1; total latency 16 cycles.

Source files
------------

// File: rtl/mul_sequencer.sv
// Bus master that arbitrates two clients onto the shared Multiplier slave, runs one
// write/start/wait/read/clear transaction per grant and hands the 128-bit product back.
module mul_sequencer #(
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic [63:0]  a0,
   input  logic [63:0]  b0,
   input  logic [63:0]  a1,
   input  logic [63:0]  b1,
   output logic         done0,
   output logic         done1,
   output logic [127:0] result,
   output logic         err,
   output logic         busy,
   output logic         M_sel,
   output logic         M_wr,
   output logic [7:0]   M_address,
   output logic [31:0]  M_din,
   input  logic [31:0]  M_dout,
   input  logic         m_interrupt
);

   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WRITE, WAIT, READ, CLEAR, DONE} state_t;

   state_t         state, state_n;
   logic [2:0]     step, step_n;
   logic [WCW-1:0] wait_cnt, wait_cnt_n;
   logic [63:0]    op_a, op_a_n, op_b, op_b_n;
   logic           grant, grant_n;
   logic           last_grant, last_grant_n;
   logic           err_flag, err_flag_n;
   logic [127:0]   result_n;
   logic [1:0]     word_idx;
   logic           sel_n, wr_n;
   logic [7:0]     addr_n;
   logic [31:0]    din_n;

   // Read step k captures the word addressed during step k-1 (slave read data lags by one cycle)
   assign word_idx = step[1:0] - 2'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         step       <= '0;
         wait_cnt   <= '0;
         op_a       <= '0;
         op_b       <= '0;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         err_flag   <= 1'b0;
         result     <= '0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
         M_sel      <= 1'b0;
         M_wr       <= 1'b0;
         M_address  <= '0;
         M_din      <= '0;
      end else begin
         state      <= state_n;
         step       <= step_n;
         wait_cnt   <= wait_cnt_n;
         op_a       <= op_a_n;
         op_b       <= op_b_n;
         grant      <= grant_n;
         last_grant <= last_grant_n;
         err_flag   <= err_flag_n;
         result     <= result_n;
         done0      <= (state_n == DONE) && !grant_n;
         done1      <= (state_n == DONE) && grant_n;
         err        <= (state_n == DONE) && err_flag_n;
         busy       <= (state_n != IDLE);
         M_sel      <= sel_n;
         M_wr       <= wr_n;
         M_address  <= addr_n;
         M_din      <= din_n;
      end
   end

   always_comb begin
      state_n      = state;
      step_n       = step;
      wait_cnt_n   = wait_cnt;
      op_a_n       = op_a;
      op_b_n       = op_b;
      grant_n      = grant;
      last_grant_n = last_grant;
      err_flag_n   = err_flag;
      result_n     = result;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant_n = (req0 && req1) ? ~last_grant : req1;
               op_a_n  = grant_n ? a1 : a0;
               op_b_n  = grant_n ? b1 : b0;
               step_n  = '0;
               state_n = WRITE;
            end
         end
         WRITE: begin
            if (step == 3'd6) begin
               wait_cnt_n = '0;
               state_n    = WAIT;
            end else begin
               step_n = step + 3'd1;
            end
         end
         WAIT: begin
            if (m_interrupt) begin
               step_n  = '0;
               state_n = READ;
            end else if (wait_cnt == WAIT_LAST) begin
               err_flag_n = 1'b1;
               state_n    = CLEAR;
            end else begin
               wait_cnt_n = wait_cnt + 1'b1;
            end
         end
         READ: begin
            if (step != 3'd0)
               result_n[{word_idx, 5'd0} +: 32] = M_dout;
            if (step == 3'd4)
               state_n = CLEAR;
            else
               step_n = step + 3'd1;
         end
         CLEAR: state_n = DONE;
         DONE: begin
            last_grant_n = grant;
            err_flag_n   = 1'b0;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Bus values are decoded from the upcoming state so the registered strobes line up with it
      sel_n  = 1'b0;
      wr_n   = 1'b0;
      addr_n = '0;
      din_n  = '0;
      case (state_n)
         WRITE: begin
            sel_n = 1'b1;
            wr_n  = 1'b1;
            case (step_n)
               3'd0:    begin addr_n = 8'h0; din_n = op_a_n[31:0];  end
               3'd1:    begin addr_n = 8'h1; din_n = op_a_n[63:32]; end
               3'd2:    begin addr_n = 8'h2; din_n = op_b_n[31:0];  end
               3'd3:    begin addr_n = 8'h3; din_n = op_b_n[63:32]; end
               3'd4:    begin addr_n = 8'h8; din_n = 32'd1;         end
               3'd5:    begin addr_n = 8'hA; din_n = 32'd1;         end
               default: begin addr_n = 8'hA; din_n = 32'd0;         end
            endcase
         end
         READ: begin
            sel_n = 1'b1;
            if (step_n < 3'd4)
               addr_n = 8'h4 + {5'd0, step_n};
         end
         CLEAR: begin
            sel_n  = 1'b1;
            wr_n   = 1'b1;
            addr_n = 8'hB;
            din_n  = 32'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized self-checking bench for mul_sequencer with a behavioural Multiplier slave.
module tb_mul_sequencer;

   localparam logic [31:0] K = 32'hC0DE_0001;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req0 = 1'b0, req1 = 1'b0;
   logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic done0, done1, err, busy, m_sel, m_wr, m_interrupt;
   logic [127:0] result;
   logic [7:0] m_address;
   logic [31:0] m_din, m_dout;

   logic req2 = 1'b0, irq2 = 1'b0;
   logic [63:0] a2 = '0, b2 = '0;
   logic done20, done21, err2, busy2, m_sel2, m_wr2;
   logic [127:0] result2;
   logic [7:0] m_address2;
   logic [31:0] m_din2;

   int compared = 0, mismatched = 0;
   int last_served = 1;
   logic [39:0] writes[$];
   logic [7:0] reads[$];

   always #5 clk = ~clk;

   mul_sequencer dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
      .M_sel(m_sel), .M_wr(m_wr), .M_address(m_address), .M_din(m_din),
      .M_dout(m_dout), .m_interrupt(m_interrupt)
   );

   mul_sequencer #(.TIMEOUT(16)) dut_to (
      .clk(clk), .reset(reset), .req0(req2), .req1(1'b0),
      .a0(a2), .b0(b2), .a1(64'd0), .b1(64'd0),
      .done0(done20), .done1(done21), .result(result2), .err(err2), .busy(busy2),
      .M_sel(m_sel2), .M_wr(m_wr2), .M_address(m_address2), .M_din(m_din2),
      .M_dout(K), .m_interrupt(irq2)
   );

   // Slave model: registers, product computed on start, interrupt raised latency edges later
   logic [63:0] s_a, s_b;
   logic [127:0] s_p;
   logic s_irq;
   int s_cnt;
   int slave_latency = 1;
   logic irq_force = 1'b0;
   assign m_interrupt = s_irq | irq_force;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s_a <= '0; s_b <= '0; s_p <= '0; s_irq <= 1'b0; s_cnt <= 0; m_dout <= '0;
      end else begin
         if (m_sel && m_wr && m_address == 8'hA && m_din == 32'd1)
            s_cnt <= slave_latency;
         else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) s_irq <= 1'b1;
         end
         if (m_sel && m_wr) begin
            case (m_address)
               8'h0: s_a[31:0]  <= m_din;
               8'h1: s_a[63:32] <= m_din;
               8'h2: s_b[31:0]  <= m_din;
               8'h3: s_b[63:32] <= m_din;
               8'hA: if (m_din == 32'd1) s_p <= {64'd0, s_a} * {64'd0, s_b};
               8'hB: if (m_din == 32'd1) s_irq <= 1'b0;
               default: ;
            endcase
         end
         m_dout <= '0;
         if (m_sel && !m_wr && m_address >= 8'h4 && m_address <= 8'h7)
            m_dout <= s_p[(int'(m_address) - 4) * 32 +: 32];
      end
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      last_served = 1;
   endtask

   task automatic applyStimulus(input int client, input logic [63:0] a, input logic [63:0] b);
      @(posedge clk);
      #1;
      if (client == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
      else begin a1 = a; b1 = b; req1 = 1'b1; end
   endtask

   // Cycle 1 is the grant cycle; returns on the negedge inside the cycle that shows done
   task automatic waitDone(input int inst, input int budget, output int cycles);
      bit seen;
      logic s, w, d;
      logic [7:0] ad;
      logic [31:0] dn;
      seen = 1'b0;
      cycles = 0;
      writes.delete();
      reads.delete();
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (inst == 0) begin s = m_sel; w = m_wr; ad = m_address; dn = m_din; d = done0 | done1; end
         else begin s = m_sel2; w = m_wr2; ad = m_address2; dn = m_din2; d = done20 | done21; end
         if (s && w) writes.push_back({ad, dn});
         else if (s) reads.push_back(ad);
         seen = d;
      end
      checkOutput("doneSeen", seen, 1);
   endtask

   task automatic verifyOp(input int inst, input int exp_client, input logic [127:0] exp_result,
                           input logic exp_err, input int exp_cycles, input int cycles);
      if (inst == 0) begin
         checkOutput("doneWho", {done1, done0}, (exp_client == 1) ? 2'b10 : 2'b01);
         checkOutput("result", result, exp_result);
         checkOutput("err", err, exp_err);
      end else begin
         checkOutput("doneWho2", {done21, done20}, 2'b01);
         checkOutput("result2", result2, exp_result);
         checkOutput("err2", err2, exp_err);
      end
      if (exp_cycles > 0) checkOutput("latency", cycles, exp_cycles);
   endtask

   task automatic checkTrace(input logic [63:0] a, input logic [63:0] b, input int exp_reads);
      logic [39:0] exp_w[8];
      exp_w[0] = {8'h0, a[31:0]};  exp_w[1] = {8'h1, a[63:32]};
      exp_w[2] = {8'h2, b[31:0]};  exp_w[3] = {8'h3, b[63:32]};
      exp_w[4] = {8'h8, 32'd1};    exp_w[5] = {8'hA, 32'd1};
      exp_w[6] = {8'hA, 32'd0};    exp_w[7] = {8'hB, 32'd1};
      checkOutput("writeCount", writes.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < writes.size()) checkOutput($sformatf("write%0d", i), writes[i], exp_w[i]);
      checkOutput("readCount", reads.size(), exp_reads);
      for (int i = 0; i < 4; i++)
         if (i < reads.size() && exp_reads > 0) checkOutput($sformatf("read%0d", i), reads[i], 4 + i);
   endtask

   // Spec latency: grant cycle + 7 writes + W waits + 5 reads + clear + done, W = max(1, latency)
   task automatic runSingle(input int client, input logic [63:0] a, input logic [63:0] b,
                            input int lat, input logic force_irq);
      int cyc;
      int w;
      slave_latency = lat;
      irq_force = force_irq;
      w = (force_irq || lat < 1) ? 1 : lat;
      applyStimulus(client, a, b);
      waitDone(0, 400, cyc);
      req0 = 1'b0;
      req1 = 1'b0;
      verifyOp(0, client, {64'd0, a} * {64'd0, b}, 1'b0, 15 + w, cyc);
      checkTrace(a, b, 5);
      last_served = client;
      @(negedge clk);
      checkOutput("donePulse", {done1, done0}, 2'b00);
      irq_force = 1'b0;
   endtask

   initial begin
      int cyc;
      int expc;
      logic [63:0] ra, rb;

      applyReset();
      checkOutput("resetResult", result, 0);
      checkOutput("resetCtl", {done0, done1, err, busy, m_sel, m_wr, m_address, m_din}, 0);

      runSingle(0, 64'h20, 64'h19, 36, 1'b0);
      checkOutput("product320", result, 128'h320);
      runSingle(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0);
      checkOutput("fullWidth", result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      runSingle(0, {$urandom, $urandom}, {$urandom, $urandom}, 1, 1'b1);
      for (int i = 0; i < 6; i++)
         runSingle(int'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(1, 40)), 1'b0);

      // Reset while the sequencer waits for the interrupt
      slave_latency = 30;
      applyStimulus(0, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (12) @(negedge clk);
      checkOutput("busyInWait", busy, 1);
      #1 reset = 1'b1;
      #1;
      checkOutput("asyncResult", result, 0);
      checkOutput("asyncCtl", {done0, done1, err, busy, m_sel, m_wr, m_address, m_din}, 0);
      a0 = {$urandom, $urandom};
      b0 = {$urandom, $urandom};
      slave_latency = 5;
      repeat (2) begin
         @(negedge clk);
         checkOutput("noDoneInReset", {done0, done1}, 2'b00);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      last_served = 1;
      waitDone(0, 400, cyc);
      req0 = 1'b0;
      verifyOp(0, 0, {64'd0, a0} * {64'd0, b0}, 1'b0, 20, cyc);
      last_served = 0;

      // Both clients always pending: service must alternate starting with client 0
      applyReset();
      slave_latency = int'($urandom_range(1, 20));
      @(posedge clk);
      #1;
      a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      req0 = 1'b1;
      req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         waitDone(0, 400, cyc);
         expc = (last_served == 1) ? 0 : 1;
         verifyOp(0, expc, (expc == 0) ? {64'd0, a0} * {64'd0, b0} : {64'd0, a1} * {64'd0, b1},
                  1'b0, 0, cyc);
         last_served = expc;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (expc == 0) begin a0 = ra; b0 = rb; end
         else begin a1 = ra; b1 = rb; end
         slave_latency = int'($urandom_range(1, 20));
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
         @(negedge clk);
         checkOutput("donePulseTie", {done1, done0}, 2'b00);
      end

      // Short-timeout instance: one good transfer, then one that never sees the interrupt
      applyReset();
      a2 = {$urandom, $urandom};
      b2 = {$urandom, $urandom};
      irq2 = 1'b1;
      @(posedge clk);
      #1 req2 = 1'b1;
      waitDone(1, 400, cyc);
      req2 = 1'b0;
      verifyOp(1, 0, {4{K}}, 1'b0, 16, cyc);
      checkTrace(a2, b2, 5);
      @(posedge clk);
      #1;
      irq2 = 1'b0;
      req2 = 1'b1;
      waitDone(1, 400, cyc);
      req2 = 1'b0;
      verifyOp(1, 0, {4{K}}, 1'b1, 26, cyc);
      checkTrace(a2, b2, 0);
      @(negedge clk);
      checkOutput("busyAfterTimeout", busy2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
